// File: rtl/mcu0_pkg.sv
// mcu0_pkg: shared loader state encoding and memory geometry
package mcu0_pkg;
  localparam int MEM_AW = 12;
  localparam int WORD_W = 16;
  typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE, ERROR} state_t;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: gathers a high and a low byte into one big-endian word with its last flag
module byte_packer
  import mcu0_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              cap_hi,
  input  logic              cap_lo,
  input  logic [7:0]        data,
  input  logic              last_in,
  output logic [WORD_W-1:0] word,
  output logic              last
);
  logic [7:0] hi;
  // high byte waits in hi; the word only changes when its low byte lands, so it holds between writes
  always_ff @(posedge clock)
    if (reset) begin
      hi   <= '0;
      word <= '0;
      last <= 1'b0;
    end else begin
      if (cap_hi) hi <= data;
      if (cap_lo) begin
        word <= {hi, data};
        last <= last_in;
      end
    end
endmodule

// File: rtl/mcu0_loader.sv
// mcu0_loader: streams a byte image into the mcu0 memory as 16-bit words, holding the cpu until done
module mcu0_loader
  import mcu0_pkg::*;
#(
  parameter int            AW   = MEM_AW,
  parameter logic [AW-1:0] BASE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_w,
  output logic [AW-1:0]     mem_wi,
  output logic [WORD_W-1:0] mem_wd,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [AW-1:0]     word_count
);
  localparam logic [AW-1:0] TOP = {{(AW-1){1'b1}}, 1'b0};
  localparam logic [AW-1:0] SAT = {1'b1, {(AW-1){1'b0}}};
  state_t state, nxt;
  logic [AW-1:0] addr;
  logic xfer, launch, lo_xfer, word_last;
  assign xfer    = in_valid && in_ready;
  assign lo_xfer = state == LO && xfer;
  assign launch  = start && (state == IDLE || state == DONE || state == ERROR);
  byte_packer u_packer (
    .clock  (clock),
    .reset  (reset),
    .cap_hi (state == HI && xfer),
    .cap_lo (lo_xfer),
    .data   (in_data),
    .last_in(in_last),
    .word   (mem_wd),
    .last   (word_last)
  );
  // state register
  always_ff @(posedge clock) state <= reset ? IDLE : nxt;
  // next state: overflow is judged on the address of the word just written, before any increment
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? HI : IDLE;
      HI:      nxt = in_valid ? (in_last ? ERROR : LO) : HI;
      LO:      nxt = in_valid ? WRITE : LO;
      WRITE:   nxt = word_last ? DONE : (addr == TOP ? ERROR : HI);
      DONE:    nxt = start ? HI : DONE;
      ERROR:   nxt = start ? HI : ERROR;
      default: nxt = IDLE;
    endcase
  end
  // strobe and address are registered as the low byte lands so they are clean for the whole write cycle
  always_ff @(posedge clock)
    if (reset) begin
      addr       <= BASE;
      word_count <= '0;
      mem_w      <= 1'b0;
      mem_wi     <= '0;
    end else begin
      mem_w <= lo_xfer;
      if (lo_xfer) mem_wi <= addr;
      if (launch) begin
        addr       <= BASE;
        word_count <= '0;
      end else if (state == WRITE) begin
        if (word_count != SAT) word_count <= word_count + 1'b1;
        if (!word_last && addr != TOP) addr <= addr + AW'(2);
      end
    end
  // per-state status outputs
  always_comb begin
    in_ready = state == HI || state == LO;
    done     = state == DONE;
    error    = state == ERROR;
    cpu_hold = state != DONE;
  end
endmodule

// File: tb/tb_mcu0_loader.sv
// tb_mcu0_loader: randomized scoreboard bench for the byte-stream program loader
module tb_mcu0_loader;
  logic        clock = 0, reset = 1, start = 0, in_valid = 0, in_last = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready, mem_w, cpu_hold, done, error;
  logic [11:0] mem_wi, word_count;
  logic [15:0] mem_wd;
  int checks = 0, errors = 0;
  typedef struct {logic [11:0] a; logic [15:0] d;} wr_t;
  wr_t expq[$];
  logic [7:0] stream[$];

  mcu0_loader dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .mem_w(mem_w), .mem_wi(mem_wi), .mem_wd(mem_wd),
    .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every write strobe must match the oldest expected write
  always @(negedge clock)
    if (mem_w === 1'b1) begin
      wr_t e;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_wi, mem_wd);
      end else begin
        e = expq.pop_front();
        check("write_addr", 32'(mem_wi), 32'(e.a));
        check("write_data", 32'(mem_wd), 32'(e.d));
      end
    end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start;
    @(negedge clock);
    start = 1;
    @(negedge clock);
    start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l, input int gap);
    int t;
    @(negedge clock);
    in_valid = 0;
    repeat (gap) @(negedge clock);
    if (gap > 0) check("ready_in_stall", 32'(in_ready), 32'd1);
    in_valid = 1;
    in_data  = b;
    in_last  = l;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t == 50) check("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clock);
  endtask

  // reference: the image is a list of byte pairs laid out from address 0; it ends on the marked
  // byte, or as an error when the marked byte is unpaired or the 2048-word memory fills first
  task automatic run_load(input bit mark_last, input int mingap, input int maxgap,
                          input bit extra_start, input string tag);
    int n, words, written, nsend, t;
    bit exp_done;
    n        = stream.size();
    words    = n / 2;
    written  = words > 2048 ? 2048 : words;
    exp_done = mark_last && (n % 2 == 0) && words <= 2048;
    nsend    = (!exp_done && words >= 2048) ? 4096 : n;
    for (int i = 0; i < written; i++) expq.push_back('{12'(2 * i), {stream[2*i], stream[2*i+1]}});
    pulse_start;
    check({tag, "_start_count"}, 32'(word_count), 32'd0);
    check({tag, "_start_hold"}, 32'(cpu_hold), 32'd1);
    if (extra_start) begin
      pulse_start;
      check({tag, "_ignored_start_ready"}, 32'(in_ready), 32'd1);
    end
    for (int i = 0; i < nsend; i++)
      send_byte(stream[i], mark_last && i == n - 1, int'($urandom_range(maxgap, mingap)));
    @(negedge clock);
    in_valid = 0;
    in_last  = 0;
    t = 0;
    while (!(done || error) && t < 20) begin
      @(negedge clock);
      t++;
    end
    @(negedge clock);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(!exp_done));
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    check({tag, "_word_count"}, 32'(word_count), 32'(written));
    check({tag, "_ready_idle"}, 32'(in_ready), 32'd0);
    check({tag, "_pending_writes"}, 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("reset_ready", 32'(in_ready), 32'd0);
    check("reset_hold", 32'(cpu_hold), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_mem_w", 32'(mem_w), 32'd0);
    check("reset_wi", 32'(mem_wi), 32'd0);
    check("reset_wd", 32'(mem_wd), 32'd0);
    check("reset_count", 32'(word_count), 32'd0);
    reset = 0;
    repeat (2) @(negedge clock);
    check("idle_ready", 32'(in_ready), 32'd0);

    stream = {8'h00, 8'h10, 8'h10, 8'h12};
    run_load(1, 0, 0, 0, "basic");
    run_load(1, 4, 4, 0, "stalled");
    stream = {8'hAA, 8'hBB, 8'hCC};
    run_load(1, 0, 1, 1, "odd");
    stream = {8'h00, 8'h10, 8'h10, 8'h12};
    run_load(1, 0, 2, 1, "reload");

    pulse_start;
    send_byte(8'h55, 0, 0);
    @(negedge clock);
    in_valid = 0;
    reset = 1;
    @(negedge clock);
    check("midreset_mem_w", 32'(mem_w), 32'd0);
    check("midreset_ready", 32'(in_ready), 32'd0);
    check("midreset_hold", 32'(cpu_hold), 32'd1);
    check("midreset_count", 32'(word_count), 32'd0);
    reset = 0;
    stream = {8'h01, 8'h02, 8'h03, 8'h04};
    run_load(1, 0, 1, 0, "after_reset");

    for (int k = 0; k < 8; k++) begin
      int len;
      len = int'($urandom_range(16, 1));
      stream.delete();
      for (int i = 0; i < len; i++) stream.push_back(8'($urandom));
      run_load(1, 0, 3, k[0], $sformatf("rand%0d", k));
    end

    stream.delete();
    for (int i = 0; i < 4096; i++) stream.push_back(8'($urandom));
    run_load(0, 0, 0, 0, "overflow");
    run_load(1, 0, 0, 0, "full_last");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
